// File: rtl/simon_pkg.sv
// Shared Simon game types: playback FSM states, pattern colour and LED decode.
package simon_pkg;

    localparam int COLOR_W   = 2;
    localparam int MAX_LEVEL = 10;

    typedef logic [COLOR_W-1:0] color_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_DATA,
        ON,
        OFF,
        DONE
    } pb_state_t;

    function automatic logic [3:0] color_to_onehot(input color_t c);
        logic [3:0] one;
        one = 4'b0001;
        return one << c;
    endfunction

endpackage

// File: rtl/playback_timer.sv
// Loadable down-counter with a zero flag; times the lit and dark phases of a step.
module playback_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pattern_playback_ctrl.sv
// Plays pattern entries 0..L-1 on the LEDs for the game's blink phase.
// Define PLAYBACK_SPEEDUP_EN to shorten on/off times at higher levels.
module pattern_playback_ctrl #(
    parameter int ON_CYCLES  = 4,
    parameter int OFF_CYCLES = 2,
    parameter int MAX_LEVEL  = simon_pkg::MAX_LEVEL,
    parameter int ADDR_W     = 4,
    parameter int COLOR_W    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         level,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [COLOR_W-1:0] mem_rdata,
    output logic [3:0]         led,
    output logic               busy,
    output logic               done
);
    import simon_pkg::*;

    localparam int LEN_W = $clog2(MAX_LEVEL + 1);
    localparam int TMAX  = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW    = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

    pb_state_t        state, state_d;
    logic [LEN_W-1:0] idx, idx_d, len_q, len_d, lvl_clamp;
    color_t           color_q, color_d;
    logic             tmr_load, tmr_dec, tmr_zero;
    logic [TW-1:0]    tmr_val, on_ld, off_ld;

    assign lvl_clamp = (32'(level) > MAX_LEVEL) ? LEN_W'(MAX_LEVEL) : LEN_W'(level);

`ifdef PLAYBACK_SPEEDUP_EN
    logic [TW-1:0] on_q, off_q;

    // Returns the effective duration minus one, ready to load into the timer.
    function automatic logic [TW-1:0] scaled(input int base, input logic [LEN_W-1:0] n);
        int v;
        if (n >= LEN_W'(7))
            v = base >> 2;
        else if (n >= LEN_W'(4))
            v = base >> 1;
        else
            v = base;
        if (v < 1)
            v = 1;
        return TW'(v - 1);
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            on_q  <= '0;
            off_q <= '0;
        end else if (state == IDLE && start) begin
            on_q  <= scaled(ON_CYCLES, lvl_clamp);
            off_q <= scaled(OFF_CYCLES, lvl_clamp);
        end
    end

    assign on_ld  = on_q;
    assign off_ld = off_q;
`else
    assign on_ld  = TW'(ON_CYCLES - 1);
    assign off_ld = TW'(OFF_CYCLES - 1);
`endif

    playback_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            idx     <= '0;
            len_q   <= '0;
            color_q <= '0;
        end else begin
            state   <= state_d;
            idx     <= idx_d;
            len_q   <= len_d;
            color_q <= color_d;
        end
    end

    always_comb begin
        state_d  = state;
        idx_d    = idx;
        len_d    = len_q;
        color_d  = color_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    len_d   = lvl_clamp;
                    idx_d   = '0;
                    state_d = (lvl_clamp == '0) ? DONE : FETCH;
                end
            end
            FETCH: state_d = WAIT_DATA;
            WAIT_DATA: begin
                color_d  = color_t'(mem_rdata);
                tmr_load = 1'b1;
                tmr_val  = on_ld;
                state_d  = ON;
            end
            ON: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = off_ld;
                    state_d  = OFF;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            OFF: begin
                if (tmr_zero) begin
                    if (idx == len_q - LEN_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx + LEN_W'(1);
                        state_d = FETCH;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Dropping start mid-playback abandons it silently.
        if (!start && (state == FETCH || state == WAIT_DATA || state == ON || state == OFF))
            state_d = IDLE;
    end

    assign mem_rd_en = (state == FETCH);
    assign mem_addr  = ADDR_W'(idx);
    assign led       = (state == ON) ? color_to_onehot(color_q) : 4'b0000;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule
